// File: rtl/msk_enc_pkg.sv
// Shared constants, state encoding and LFSR step function for the MSK share encoder.
// DEFAULTSHARES sets the default share count when the build does not provide it.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

package msk_enc_pkg;

  localparam int LFSR_W       = 64;
  localparam int WARMUP_STEPS = 64;

  // Galois taps for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting form)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } enc_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = {1'b0, s[LFSR_W-1:1]};
    if (s[0]) begin
      n = n ^ LFSR_TAPS;
    end else begin
      n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/msk_lfsr64.sv
// 64-bit Galois LFSR with seed load (zero seed maps to 1) and step enable.
module msk_lfsr64
  import msk_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Load wins over step so a reseed always restarts from a known value.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == 64'h0) ? 64'h1 : seed;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 64'h1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/msk_share_encoder.sv
// Masks W-bit plaintext into d bit-sliced Boolean shares using LFSR randomness.
// Optional MSK_ENC_SELFCHECK_EN adds a sticky err output (recombination / zero-LFSR check).
module msk_share_encoder
  import msk_enc_pkg::*;
#(
  parameter int d = `DEFAULTSHARES,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [63:0]    seed,
  input  logic           seed_valid,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W*d-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
`ifdef MSK_ENC_SELFCHECK_EN
  ,
  output logic           err
`endif
);

  localparam int CNT_W = $clog2(WARMUP_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP_STEPS - 1);

  if (d < 2 || (d - 1) * W > LFSR_W) begin : g_param_chk
    $error("msk_share_encoder: need d>=2 and (d-1)*W<=64");
  end

  enc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [W*d-1:0]    out_data_q, out_data_d;
  logic [W*d-1:0]    share_s;
  logic [LFSR_W-1:0] lfsr_s;
  logic              accept_s;
  logic              lfsr_step_s;

  assign in_ready    = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept_s    = in_valid && in_ready && !seed_valid;
  assign lfsr_step_s = (state_q == WARMUP) || accept_s;
  assign busy        = (state_q != RUN);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;

  msk_lfsr64 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_valid),
    .seed  (seed),
    .step  (lfsr_step_s),
    .state (lfsr_s)
  );

  // Random share i of bit b is lfsr[(i-1)*W + b]; share 0 absorbs the plaintext.
  for (genvar b = 0; b < W; b++) begin : g_bit
    logic [d-2:0] r_s;
    for (genvar i = 1; i < d; i++) begin : g_sh
      assign r_s[i-1]          = lfsr_s[(i-1)*W + b];
      assign share_s[b*d + i]  = r_s[i-1];
    end
    assign share_s[b*d] = in_data[b] ^ (^r_s);
  end

  if ((d - 1) * W < LFSR_W) begin : g_unused
    logic unused_lfsr_s;
    assign unused_lfsr_s = ^lfsr_s[LFSR_W-1:(d-1)*W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (seed_valid) begin
          state_d = WARMUP;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WARMUP: begin
        if (seed_valid) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (seed_valid) begin
          state_d = WARMUP;
          cnt_d   = '0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A pending beat drains independently of reseeding; data holds under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = share_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef MSK_ENC_SELFCHECK_EN
  logic [W-1:0] pt_q, pt_d;
  logic [W-1:0] recomb_s;
  logic         err_q, err_d;

  for (genvar b = 0; b < W; b++) begin : g_rc
    assign recomb_s[b] = ^out_data_q[b*d +: d];
  end

  always_comb begin
    pt_d  = accept_s ? in_data : pt_q;
    err_d = err_q
          | (out_valid_q && (recomb_s != pt_q))
          | (lfsr_s == 64'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pt_q  <= pt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_msk_share_encoder.sv
// Scoreboard bench for msk_share_encoder (d=2, W=8): driver pushes expectations, monitor checks beats.
module tb_msk_share_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] seed = 64'h0;
  logic        seed_valid = 1'b0;
  logic [7:0]  in_data = 8'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
`ifdef MSK_ENC_SELFCHECK_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  msk_share_encoder #(.d(2), .W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed       (seed),
    .seed_valid (seed_valid),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
`ifdef MSK_ENC_SELFCHECK_EN
    ,
    .err        (err)
`endif
  );

  typedef struct {
    logic [15:0] data;
    logic [7:0]  pt;
    int          due;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [63:0] m_lfsr = 64'h1;
  logic [15:0] last_exp = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Independent model: shift right, feed the dropped bit into taps 63,62,60,59.
  function automatic logic [63:0] m_step(input logic [63:0] s);
    logic [63:0] n;
    n = {1'b0, s[63:1]};
    if (s[0]) begin
      n[63] = ~n[63];
      n[62] = ~n[62];
      n[60] = ~n[60];
      n[59] = ~n[59];
    end
    return n;
  endfunction

  function automatic logic [15:0] m_share(input logic [7:0] v, input logic [63:0] l);
    logic [15:0] o;
    for (int b = 0; b < 8; b++) begin
      o[2*b]   = v[b] ^ l[b];
      o[2*b+1] = l[b];
    end
    return o;
  endfunction

  task automatic do_seed(input logic [63:0] s);
    seed = s;
    seed_valid = 1'b1;
    @(posedge clk);
    #1;
    seed_valid = 1'b0;
    in_valid = 1'b0;
    m_lfsr = (s == 64'h0) ? 64'h1 : s;
    repeat (64) m_lfsr = m_step(m_lfsr);
  endtask

  task automatic warm_check(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(n), 64'd64);
    check({name, "_in_ready"}, {63'h0, in_ready}, 64'h1);
    check({name, "_lfsr"}, dut.u_lfsr.state, m_lfsr);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input bit lat);
    int n = 0;
    in_data = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for data %h", v);
    end else begin
      last_exp = m_share(v, m_lfsr);
      sb.push_back('{data: last_exp, pt: v, due: cyc + 1, lat: lat});
      m_lfsr = m_step(m_lfsr);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every beat taken by the sink is checked against the scoreboard head.
  initial begin : monitor
    exp_t       e;
    logic [7:0] rc;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %h expected no beat", out_data);
        end else begin
          e = sb.pop_front();
          for (int b = 0; b < 8; b++) rc[b] = out_data[2*b] ^ out_data[2*b+1];
          check("beat_data", {48'h0, out_data}, {48'h0, e.data});
          check("beat_recombine", {56'h0, rc}, {56'h0, e.pt});
          if (e.lat) check("beat_latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h1);
    check("rst_in_ready", {63'h0, in_ready}, 64'h0);
    check("rst_out_data", {48'h0, out_data}, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", {63'h0, busy}, 64'h1);
    check("idle_in_ready", {63'h0, in_ready}, 64'h0);
    @(posedge clk);
    #1;

    do_seed(64'h0123456789ABCDEF);
    warm_check("warmup");

    out_ready = 1'b1;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'hA5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("stream_drained", 64'(sb.size()), 64'd0);

    out_ready = 1'b0;
    send(8'h3C, 1'b0);
    in_data = 8'h5A;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", {63'h0, in_ready}, 64'h0);
      check("bp_out_valid", {63'h0, out_valid}, 64'h1);
      check("bp_out_data", {48'h0, out_data}, {48'h0, last_exp});
      check("bp_lfsr", dut.u_lfsr.state, m_lfsr);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h5A, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", 64'(sb.size()), 64'd0);

    in_data = 8'hC3;
    in_valid = 1'b1;
    do_seed(64'hFEDCBA9876543210);
    warm_check("simul");

    out_ready = 1'b0;
    send(8'h77, 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", {63'h0, out_valid}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    check("midrst_busy", {63'h0, busy}, 64'h1);
    check("midrst_in_ready", {63'h0, in_ready}, 64'h0);
    check("midrst_out_data", {48'h0, out_data}, 64'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_in_ready", {63'h0, in_ready}, 64'h0);
    end
    @(posedge clk);
    #1;

    do_seed(64'h0);
    warm_check("seed0");
    send(8'h5A, 1'b1);
    send(8'h81, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("seed0_drained", 64'(sb.size()), 64'd0);

`ifdef MSK_ENC_SELFCHECK_EN
    check("sc_err_clear", {63'h0, err}, 64'h0);
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    @(negedge clk);
    force dut.out_data_q = last_exp ^ 16'h0001;
    @(posedge clk);
    #1;
    release dut.out_data_q;
    @(negedge clk);
    check("sc_err_set", {63'h0, err}, 64'h1);
    repeat (4) begin
      @(negedge clk);
      check("sc_err_sticky", {63'h0, err}, 64'h1);
    end
    rst_n = 1'b0;
    #1;
    check("sc_err_reset", {63'h0, err}, 64'h0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
